// File: rtl/lifting_dwt53_line.sv
// Single-level 1-D LeGall 5/3 lifting decomposition of one image line, streamed.
// Define LIFTING_PERIODIC_EXT_EN for periodic boundary extension (default: symmetric).
module lifting_dwt53_line #(
  parameter int DATA_W   = 16,
  parameter int LINE_LEN = 64,
  parameter int ADDR_W   = 16,
  parameter int LADDR_W  = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [LADDR_W-1:0] line_addr,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W+1:0]  out_low,
  output logic [DATA_W+1:0]  out_high,
  output logic [ADDR_W-1:0]  out_low_addr,
  output logic [ADDR_W-1:0]  out_high_addr,
  output logic               out_last,
  output logic               busy,
  output logic [1:0]         dbg_state
);
  localparam int IW   = DATA_W + 2;
  localparam int HALF = LINE_LEN / 2;
  localparam int CW   = $clog2(LINE_LEN) + 1;

  typedef logic signed [IW-1:0] coef_t;
  typedef enum logic [1:0] {S_IDLE, S_FILL, S_RUN, S_FLUSH} state_t;

  function automatic coef_t predict(input coef_t odd, input coef_t e0, input coef_t e1);
    logic signed [IW:0] sum;
    logic signed [IW:0] half;
    sum  = {e0[IW-1], e0} + {e1[IW-1], e1};
    half = sum >>> 1;
    return odd - half[IW-1:0];
  endfunction

  function automatic coef_t update(input coef_t even, input coef_t dp, input coef_t dk);
    logic signed [IW+1:0] u;
    logic signed [IW+1:0] sh;
    u  = {{2{dp[IW-1]}}, dp} + {{2{dk[IW-1]}}, dk} + (IW+2)'(2);
    sh = u >>> 2;
    return even + sh[IW-1:0];
  endfunction

  state_t            state_q, state_d;
  logic [CW-1:0]     n_q, n_d;
  logic [ADDR_W-1:0] base_q, base_d;
  coef_t             x_even_q, x_even_d, x_odd_q, x_odd_d, d_prev_q, d_prev_d;
  logic              fin_q, fin_d;
  logic              out_valid_q, out_valid_d, out_last_q, out_last_d;
  coef_t             out_low_q, out_low_d, out_high_q, out_high_d;
  logic [ADDR_W-1:0] out_low_addr_q, out_low_addr_d, out_high_addr_q, out_high_addr_d;
`ifdef LIFTING_PERIODIC_EXT_EN
  coef_t             x0_q, x0_d, d0_q, d0_d;
  logic              phase_q, phase_d;
`endif

  coef_t         in_x, d_run, s_run, d_fin, s_fin, ld_low, ld_high;
  logic [CW-1:0] ld_k;
  logic          slot_free, produce_pair, accept, begin_line, ld_en, ld_last;

  assign in_x      = {{2{in_data[DATA_W-1]}}, in_data};
  assign slot_free = !out_valid_q || out_ready;
`ifdef LIFTING_PERIODIC_EXT_EN
  // s_0 needs d_{LINE_LEN/2-1}, so x[2] only records d_0 and emits nothing.
  assign produce_pair = (state_q == S_RUN) && !n_q[0] && (n_q != CW'(2));
  assign d_fin        = predict(x_odd_q, x_even_q, x0_q);
`else
  assign produce_pair = (state_q == S_RUN) && !n_q[0];
  assign d_fin        = predict(x_odd_q, x_even_q, x_even_q);
`endif
  assign s_fin = update(x_even_q, d_prev_q, d_fin);
  assign d_run = predict(x_odd_q, x_even_q, in_x);
  assign s_run = update(x_even_q, (n_q == CW'(2)) ? d_run : d_prev_q, d_run);

  // Handshakes: a transfer happens on a rising edge where valid && ready; valid
  // never waits on ready, and a presented pair holds all fields until taken.
  assign in_ready = (state_q == S_FILL) ||
                    ((state_q == S_RUN) && (!produce_pair || slot_free));
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d = state_q;  n_d = n_q;  base_d = base_q;  fin_d = fin_q;
    x_even_d = x_even_q;  x_odd_d = x_odd_q;  d_prev_d = d_prev_q;
    out_valid_d = out_valid_q;  out_last_d = out_last_q;
    out_low_d = out_low_q;  out_high_d = out_high_q;
    out_low_addr_d = out_low_addr_q;  out_high_addr_d = out_high_addr_q;
`ifdef LIFTING_PERIODIC_EXT_EN
    x0_d = x0_q;  d0_d = d0_q;  phase_d = phase_q;
`endif
    begin_line = 1'b0;
    ld_en = 1'b0;  ld_low = '0;  ld_high = '0;  ld_k = '0;  ld_last = 1'b0;
    if (out_valid_q && out_ready) out_valid_d = 1'b0;
    case (state_q)
      S_IDLE: begin_line = start;
      S_FILL: if (accept) begin
        n_d = n_q + CW'(1);
        if (!n_q[0]) begin
          x_even_d = in_x;
`ifdef LIFTING_PERIODIC_EXT_EN
          x0_d = in_x;
`endif
        end else begin
          x_odd_d = in_x;
          state_d = S_RUN;
        end
      end
      S_RUN: if (accept) begin
        n_d = n_q + CW'(1);
        if (!n_q[0]) begin
          x_even_d = in_x;
          d_prev_d = d_run;
`ifdef LIFTING_PERIODIC_EXT_EN
          if (n_q == CW'(2)) d0_d = d_run;
`endif
          ld_en   = produce_pair;
          ld_low  = s_run;
          ld_high = d_run;
          ld_k    = (n_q >> 1) - CW'(1);
        end else begin
          x_odd_d = in_x;
          if (n_q == CW'(LINE_LEN - 1)) state_d = S_FLUSH;
        end
      end
      S_FLUSH: begin
        if (fin_q) begin
          if (out_valid_q && out_ready) begin
            state_d    = S_IDLE;
            begin_line = start;
          end
        end else if (slot_free) begin
          ld_en = 1'b1;
`ifdef LIFTING_PERIODIC_EXT_EN
          if (!phase_q) begin
            ld_low = s_fin;  ld_high = d_fin;  ld_k = CW'(HALF - 1);
            d_prev_d = d_fin;
            phase_d  = 1'b1;
          end else begin
            ld_low = update(x0_q, d_prev_q, d0_q);  ld_high = d0_q;  ld_k = '0;
            ld_last = 1'b1;
            fin_d   = 1'b1;
          end
`else
          ld_low = s_fin;  ld_high = d_fin;  ld_k = CW'(HALF - 1);
          ld_last = 1'b1;
          fin_d   = 1'b1;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (begin_line) begin
      state_d = S_FILL;
      n_d     = '0;
      fin_d   = 1'b0;
      base_d  = ADDR_W'(line_addr) * ADDR_W'(LINE_LEN);
`ifdef LIFTING_PERIODIC_EXT_EN
      phase_d = 1'b0;
`endif
    end
    if (ld_en) begin
      out_valid_d     = 1'b1;
      out_low_d       = ld_low;
      out_high_d      = ld_high;
      out_low_addr_d  = base_q + ADDR_W'(ld_k);
      out_high_addr_d = base_q + ADDR_W'(HALF) + ADDR_W'(ld_k);
      out_last_d      = ld_last;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;  n_q <= '0;  base_q <= '0;  fin_q <= 1'b0;
      x_even_q <= '0;  x_odd_q <= '0;  d_prev_q <= '0;
      out_valid_q <= 1'b0;  out_last_q <= 1'b0;  out_low_q <= '0;  out_high_q <= '0;
      out_low_addr_q <= '0;  out_high_addr_q <= '0;
`ifdef LIFTING_PERIODIC_EXT_EN
      x0_q <= '0;  d0_q <= '0;  phase_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;  n_q <= n_d;  base_q <= base_d;  fin_q <= fin_d;
      x_even_q <= x_even_d;  x_odd_q <= x_odd_d;  d_prev_q <= d_prev_d;
      out_valid_q <= out_valid_d;  out_last_q <= out_last_d;
      out_low_q <= out_low_d;  out_high_q <= out_high_d;
      out_low_addr_q <= out_low_addr_d;  out_high_addr_q <= out_high_addr_d;
`ifdef LIFTING_PERIODIC_EXT_EN
      x0_q <= x0_d;  d0_q <= d0_d;  phase_q <= phase_d;
`endif
    end
  end

  assign out_valid     = out_valid_q;
  assign out_low       = out_low_q;
  assign out_high      = out_high_q;
  assign out_low_addr  = out_low_addr_q;
  assign out_high_addr = out_high_addr_q;
  assign out_last      = out_last_q;
  assign busy          = (state_q != S_IDLE);
  assign dbg_state     = state_q;
endmodule
